// File: rtl/servo_pkg.sv
// Shared servo decode constants, FSM state type and cycle-scaling helper.
// Nominal values assume a 100 MHz clock (100000 cycles per millisecond).
package servo_pkg;

  localparam int unsigned CLK_PER_MS_NOM = 100000;
  localparam int unsigned MIN_PULSE      = 60000;
  localparam int unsigned MAX_PULSE      = 210000;
  localparam int unsigned MAX_ANGLE      = 180;
  localparam int unsigned CONV_RATE      = (MAX_PULSE - MIN_PULSE) / MAX_ANGLE;
  localparam int unsigned PULSE_BITS     = 18;
  localparam int unsigned WIDTH_SAT      = (1 << PULSE_BITS) - 1;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    CONVERT,
    WAIT_LOW
  } state_e;

  // Rescales a nominal cycle count to another clock; elaboration-time only.
  function automatic int unsigned scale_cycles(input int unsigned nominal,
                                               input int unsigned clk_per_ms);
    return nominal / (CLK_PER_MS_NOM / clk_per_ms);
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer for the asynchronous pulse input plus rising-edge detect.
module pwm_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_fill;

  // Edges count only after a genuine low has passed through, so a pulse
  // already high when reset releases is never mistaken for a new one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_meta <= i_pwm;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/pulse_length_to_angle.sv
// Measures servo pulse high time and converts it to 0..180 degrees by repeated
// subtraction, with range, timeout and no-signal reporting.
module pulse_length_to_angle
  import servo_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = CLK_PER_MS_NOM,
  parameter int unsigned LOST_BITS  = 22,
  parameter int unsigned WIDTH_BITS = PULSE_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [15:0] angle,
  output logic        angle_valid,
  output logic        range_err,
  output logic        timeout_err,
  output logic        signal_lost
);

  localparam int unsigned MIN_W  = scale_cycles(MIN_PULSE, CLK_PER_MS);
  localparam int unsigned MAX_W  = scale_cycles(MAX_PULSE, CLK_PER_MS);
  localparam int unsigned RATE_W = (MAX_W - MIN_W) / MAX_ANGLE;

  localparam logic [WIDTH_BITS-1:0] MIN_V  = WIDTH_BITS'(MIN_W);
  localparam logic [WIDTH_BITS-1:0] MAX_V  = WIDTH_BITS'(MAX_W);
  localparam logic [WIDTH_BITS-1:0] RATE_V = WIDTH_BITS'(RATE_W);
  localparam logic [WIDTH_BITS-1:0] SAT_V  = '1;
  localparam logic [WIDTH_BITS-1:0] ONE_V  = WIDTH_BITS'(1);
  localparam logic [7:0]            ANG_V  = 8'(MAX_ANGLE);

  logic                  w_level;
  logic                  w_rise;
  state_e                r_state;
  logic [WIDTH_BITS-1:0] r_width;
  logic [WIDTH_BITS-1:0] r_rem;
  logic [7:0]            r_q;
  logic [7:0]            r_angle;
  logic                  r_oor;
  logic                  r_valid;
  logic                  r_range_err;
  logic                  r_timeout;
  logic [LOST_BITS-1:0]  r_wd;

  pwm_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pwm   (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (w_rise) begin
      r_wd <= '0;
    end else if (!(&r_wd)) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Out-of-range widths preload the clamped quotient with a zero remainder so
  // the conversion loop exits at once and both paths share one output step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_width     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_oor       <= 1'b0;
      r_angle     <= '0;
      r_valid     <= 1'b0;
      r_range_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_width <= ONE_V;
            r_state <= MEASURE;
          end
        end
        MEASURE: begin
          if (w_level) begin
            if (r_width == SAT_V) begin
              r_timeout <= 1'b1;
              r_state   <= WAIT_LOW;
            end else begin
              r_width <= r_width + ONE_V;
            end
          end else begin
            r_state <= CONVERT;
            if (r_width < MIN_V) begin
              r_q   <= '0;
              r_rem <= '0;
              r_oor <= 1'b1;
            end else if (r_width > MAX_V) begin
              r_q   <= ANG_V;
              r_rem <= '0;
              r_oor <= 1'b1;
            end else begin
              r_q   <= '0;
              r_rem <= r_width - MIN_V;
              r_oor <= 1'b0;
            end
          end
        end
        CONVERT: begin
          if (r_rem >= RATE_V && r_q < ANG_V) begin
            r_rem <= r_rem - RATE_V;
            r_q   <= r_q + 8'd1;
          end else begin
            r_angle     <= r_q;
            r_range_err <= r_oor;
            r_valid     <= 1'b1;
            r_state     <= IDLE;
          end
        end
        WAIT_LOW: begin
          if (!w_level) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign angle       = {8'd0, r_angle};
  assign angle_valid = r_valid;
  assign range_err   = r_range_err;
  assign timeout_err = r_timeout;
  assign signal_lost = &r_wd;

endmodule

// File: tb/tb_pulse_length_to_angle.sv
// Bench for pulse_length_to_angle on a 1000-cycle-per-ms clock so frames stay short:
// pulse window 600..2100 cycles, 8 cycles per degree, 12-bit width and watchdog.
module tb_pulse_length_to_angle;

  localparam int MIN_W       = 600;
  localparam int MAX_W       = 2100;
  localparam int RATE        = 8;
  localparam int MAX_ANGLE   = 180;
  localparam int SAT         = 4095;
  localparam int WD_MAX      = 4095;
  localparam int SYNC_DELAY  = 2;
  localparam int VALID_BOUND = 400;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] angle;
  logic        angle_valid;
  logic        range_err;
  logic        timeout_err;
  logic        signal_lost;

  int nChecks = 0;
  int nErrors = 0;
  int cyc     = 0;

  bit expValid[int];
  int expAngleAt[int];
  bit expErrAt[int];
  bit expTimeout[int];
  bit riseAt[int];

  pulse_length_to_angle #(
    .CLK_PER_MS (1000),
    .LOST_BITS  (12),
    .WIDTH_BITS (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .angle       (angle),
    .angle_valid (angle_valid),
    .range_err   (range_err),
    .timeout_err (timeout_err),
    .signal_lost (signal_lost)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Decode from the rules: clamp outside the window, otherwise floor division
  // capped at 180; latency counted from the cycle the low level is seen.
  function automatic void modelDecode(input int w, output int ang, output bit err,
                                      output int lat);
    int q;
    if (w < MIN_W) begin
      ang = 0; err = 1'b1; lat = 2;
    end else if (w > MAX_W) begin
      ang = MAX_ANGLE; err = 1'b1; lat = 2;
    end else begin
      q = (w - MIN_W) / RATE;
      if (q > MAX_ANGLE) q = MAX_ANGLE;
      ang = q; err = 1'b0; lat = q + 2;
    end
  endfunction

  // Every-cycle comparison of all outputs against the scheduled model events.
  initial begin : compareProc
    int anchor;
    int curAngle;
    bit curErr;
    bit rs;
    bit ev;
    bit et;
    anchor = 0; curAngle = 0; curErr = 1'b0;
    forever begin
      @(posedge clk);
      rs = rst_n;
      cyc++;
      @(negedge clk);
      ev = 1'b0;
      et = 1'b0;
      if (!rs) begin
        anchor = cyc; curAngle = 0; curErr = 1'b0;
      end else begin
        if (riseAt.exists(cyc)) anchor = cyc;
        ev = expValid.exists(cyc);
        et = expTimeout.exists(cyc);
        if (ev) begin
          curAngle = expAngleAt[cyc];
          curErr   = expErrAt[cyc];
        end
      end
      checkOutput("model angle_valid", int'(angle_valid), int'(ev));
      checkOutput("model timeout_err", int'(timeout_err), int'(et));
      checkOutput("model angle", int'(angle), curAngle);
      checkOutput("model range_err", int'(range_err), int'(curErr));
      checkOutput("model signal_lost", int'(signal_lost), ((cyc - anchor) >= WD_MAX) ? 1 : 0);
    end
  end

  task automatic applyStimulus(input string name, input int n, input int litAngle,
                               input bit litErr, input int litLat, input bit litTimeout);
    int c, f, ang, lat, vcObs, toObs, validCount, obsAngle, vc;
    bit err, obsErr;
    vcObs = -1; toObs = -1; validCount = 0; obsAngle = -1; obsErr = 1'b0;
    modelDecode(n, ang, err, lat);
    @(posedge clk); #1;
    c = cyc;
    pwm_in = 1'b1;
    riseAt[c + 3] = 1'b1;
    if (n > SAT) begin
      expTimeout[c + SAT + 3] = 1'b1;
    end else begin
      vc = c + n + SYNC_DELAY + lat;
      expValid[vc]   = 1'b1;
      expAngleAt[vc] = ang;
      expErrAt[vc]   = err;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (timeout_err && toObs < 0) toObs = cyc;
      if (angle_valid) validCount++;
      @(posedge clk);
    end
    #1;
    f = cyc;
    pwm_in = 1'b0;
    for (int k = 0; k < VALID_BOUND; k++) begin
      @(negedge clk);
      if (timeout_err && toObs < 0) toObs = cyc;
      if (angle_valid) begin
        validCount++;
        if (vcObs < 0) begin
          vcObs = cyc; obsAngle = int'(angle); obsErr = range_err;
        end
      end
    end
    if (litTimeout) begin
      checkOutput({name, " timeout offset"}, (toObs < 0) ? -1 : toObs - c, litLat);
      checkOutput({name, " valid count"}, validCount, 0);
    end else begin
      checkOutput({name, " valid count"}, validCount, 1);
      checkOutput({name, " latency"}, (vcObs < 0) ? -1 : vcObs - f, litLat + SYNC_DELAY);
      checkOutput({name, " angle"}, obsAngle, litAngle);
      checkOutput({name, " range_err"}, int'(obsErr), int'(litErr));
      checkOutput({name, " no timeout"}, (toObs < 0) ? 0 : 1, 0);
    end
  endtask

  initial begin : mainProc
    int c, vCount, tCount;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("reset angle", int'(angle), 0);
    checkOutput("reset angle_valid", int'(angle_valid), 0);
    checkOutput("reset range_err", int'(range_err), 0);
    checkOutput("reset timeout_err", int'(timeout_err), 0);
    checkOutput("reset signal_lost", int'(signal_lost), 0);

    applyStimulus("w600",  600,  0,   1'b0, 2,   1'b0);
    applyStimulus("w608",  608,  1,   1'b0, 3,   1'b0);
    applyStimulus("w1500", 1500, 112, 1'b0, 114, 1'b0);
    applyStimulus("w2100", 2100, 180, 1'b0, 182, 1'b0);
    applyStimulus("w2040", 2040, 180, 1'b0, 182, 1'b0);
    applyStimulus("w2039", 2039, 179, 1'b0, 181, 1'b0);
    applyStimulus("w599",  599,  0,   1'b1, 2,   1'b0);
    applyStimulus("w2101", 2101, 180, 1'b1, 2,   1'b0);

    // Reset in mid-measure; the pulse is still high at release.
    @(posedge clk); #1;
    c = cyc;
    pwm_in = 1'b1;
    riseAt[c + 3] = 1'b1;
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("in-reset angle", int'(angle), 0);
    checkOutput("in-reset range_err", int'(range_err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1 pwm_in = 1'b0;
    vCount = 0; tCount = 0;
    for (int k = 0; k < VALID_BOUND; k++) begin
      @(negedge clk);
      if (angle_valid) vCount++;
      if (timeout_err) tCount++;
    end
    checkOutput("reset-abandon valid count", vCount, 0);
    checkOutput("reset-abandon timeout count", tCount, 0);
    checkOutput("reset-abandon angle", int'(angle), 0);
    checkOutput("reset-abandon range_err", int'(range_err), 0);

    applyStimulus("w5000 timeout", 5000, 0, 1'b0, SAT + 3, 1'b1);
    applyStimulus("w1200", 1200, 75, 1'b0, 77, 1'b0);
    applyStimulus("w900",  900,  37, 1'b0, 39, 1'b0);

    repeat (4200) @(posedge clk);
    @(negedge clk);
    checkOutput("watchdog signal_lost high", int'(signal_lost), 1);
    applyStimulus("w700", 700, 12, 1'b0, 14, 1'b0);
    checkOutput("watchdog signal_lost cleared", int'(signal_lost), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin : globalBound
    #3000000;
    $display("[TB] FAIL global time bound reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/pulse_length_to_angle.md
PULSE_LENGTH_TO_ANGLE -- requirements
Module: pulse_length_to_angle

Interface
REQ-001 Parameter CLK_PER_MS, default 100000, gives clock cycles per millisecond at the 100 MHz system clock.
REQ-002 Parameter LOST_BITS, default 22, sets the no-signal watchdog length to 2^LOST_BITS cycles (about 41.9 ms).
REQ-003 clk  input  1  is the system clock; all logic SHALL be rising-edge on clk.
REQ-004 rst_n  input  1  is a synchronous, active-low reset.
REQ-005 pwm_in  input  1  is the asynchronous servo-style pulse input (0.6 ms to 2.1 ms high, about 20 ms frame).
REQ-006 angle  output  16  is the unsigned decoded angle, 0 to 180 degrees, held until the next decode.
REQ-007 angle_valid  output  1  is a one-cycle strobe; angle SHALL be updated in the same cycle.
REQ-008 range_err  output  1  SHALL be set with angle_valid when the pulse was outside the 60000 to 210000 cycle window, and held until the next angle_valid.
REQ-009 timeout_err  output  1  is a one-cycle strobe when a high phase exceeds 262143 cycles.
REQ-010 signal_lost  output  1  SHALL be a level, high while no rising edge has been seen for 2^LOST_BITS cycles.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer; the rising edge is synced=1 with prev=0.
REQ-012 The FSM states SHALL be IDLE, MEASURE, CONVERT and WAIT_LOW.
REQ-013 IDLE SHALL go to MEASURE on a rising edge, with width loaded to 1.
REQ-014 MEASURE SHALL increment the 18-bit width each cycle synced=1, and go to CONVERT with W latched on the first cycle synced=0.
REQ-015 If width reaches 262143 with synced still 1, the block SHALL pulse timeout_err, produce no angle_valid, and go to WAIT_LOW.
REQ-016 WAIT_LOW SHALL return to IDLE on the first cycle synced=0.
REQ-017 On CONVERT entry: if W<60000, then angle=0 and range_err=1; if W>210000, then angle=180 and range_err=1. In both cases the result SHALL be output on the next cycle.
REQ-018 Otherwise the block SHALL set rem=W-60000 and q=0.
REQ-019 Each following cycle, while rem>=833 and q<180, the block SHALL perform rem-=833 and q+=1.
REQ-020 When the loop ends, angle=q, angle_valid=1, range_err=0, and the FSM SHALL go to IDLE.
REQ-021 angle_valid SHALL assert exactly q+2 cycles after MEASURE samples synced=0; the maximum is 182 cycles.
REQ-022 W in 209941 to 210000 SHALL clamp to 180 with no range_err.
REQ-023 The quotient SHALL be floor((W-60000)/833), with the remainder discarded.
REQ-024 Rising edges during CONVERT SHALL be ignored; that frame is dropped.
REQ-025 The watchdog counter SHALL clear on every rising edge and saturate at 2^LOST_BITS-1.
REQ-026 signal_lost SHALL be high while the watchdog counter is saturated, and fall the cycle after the next rising edge.
REQ-027 All arithmetic SHALL be unsigned; no multiplier or divider operator is used.

Reset
REQ-028 With rst_n=0 at a clk edge, the block SHALL set: state=IDLE, synchronizer=0, width=0, rem=0, q=0, angle=0, angle_valid=0, range_err=0, timeout_err=0, watchdog=0, signal_lost=0.
REQ-029 Reset during MEASURE or CONVERT SHALL abandon the decode with no angle_valid.
REQ-030 A pulse already high when rst_n releases SHALL not be measured, because it has no rising edge.

Structure
REQ-031 A shared package servo_pkg SHALL hold:
- MIN_PULSE=60000 and MAX_PULSE=210000;
- CONV_RATE=(MAX-MIN)/180=833 and MAX_ANGLE=180;
- WIDTH_SAT=262143;
- the FSM state enum.
REQ-032 The encoder module SHALL use the same servo_pkg constants.
REQ-033 One sub-module, pwm_sync, SHALL contain the 2-flop synchronizer and the edge detector.

Verification
REQ-034 A high phase of 60000 cycles SHALL give angle=0, range_err=0, with angle_valid 2 cycles after the fall.
REQ-035 A high phase of 150000 cycles SHALL give angle=108, with angle_valid 110 cycles after the fall.
REQ-036 High phases of 210000 and 209940 cycles SHALL each give angle=180, range_err=0.
REQ-037 High phases of 59999 and 210001 cycles SHALL give angle=0/range_err=1 and angle=180/range_err=1 respectively.
REQ-038 A high phase held for 300000 cycles SHALL give one timeout_err pulse, no angle_valid, and correct decode of the next 120000 pulse (angle=72).
REQ-039 pwm_in low for 2^22 cycles SHALL assert signal_lost. Pulsing rst_n low mid-MEASURE SHALL produce no angle_valid and leave all outputs at their reset values.
